// File: rtl/nios_pio_in_irq.sv
// Avalon-MM input PIO: 2-FF synchroniser, tick-sampled debouncer, edge capture and a masked level IRQ.
// Per-channel state is held in an instance array of nios_pio_in_irq_bit.

module nios_pio_in_irq_bit #(
   parameter bit BYPASS    = 1'b0,
   parameter int EDGE_TYPE = 0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic level,
   input  logic clr,
   output logic deb,
   output logic ec
);
   logic samp, edge_q, rise, fall, ev;

   assign rise = deb & ~edge_q;
   assign fall = ~deb & edge_q;
   assign ev   = (EDGE_TYPE == 0) ? rise : (EDGE_TYPE == 1) ? fall : (rise | fall);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         samp   <= 1'b0;
         deb    <= 1'b0;
         edge_q <= 1'b0;
         ec     <= 1'b0;
      end else begin
         edge_q <= deb;
         // a fresh event beats a coincident write-1-to-clear
         ec     <= ev | (ec & ~clr);
         if (BYPASS) begin
            deb <= level;
         end else if (tick) begin
            samp <= level;
            if (level == samp) deb <= level;
         end
      end
   end
endmodule

module nios_pio_in_irq #(
   parameter int WIDTH        = 10,
   parameter int DEBOUNCE_CYC = 4,
   parameter int EDGE_TYPE    = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   localparam int CW     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam bit BYPASS = (DEBOUNCE_CYC == 0);

   logic [WIDTH-1:0] sync1, sync2, deb, ec, irqmask, clr;
   logic             tick, wr_en;
   logic             unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign clr          = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   generate
      if (!BYPASS) begin : g_pre
         logic [CW-1:0] cnt;
         assign tick = (cnt == CW'(DEBOUNCE_CYC - 1));
         always_ff @(posedge clk) begin
            if (!reset_n)  cnt <= '0;
            else if (tick) cnt <= '0;
            else           cnt <= cnt + CW'(1);
         end
      end else begin : g_nopre
         assign tick = 1'b1;
      end
   endgenerate

   nios_pio_in_irq_bit #(.BYPASS(BYPASS), .EDGE_TYPE(EDGE_TYPE)) u_bit [WIDTH-1:0] (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .level   (sync2),
      .clr     (clr),
      .deb     (deb),
      .ec      (ec)
   );

   always_ff @(posedge clk) begin
      if (!reset_n)                        irqmask <= '0;
      else if (wr_en && address == 2'd1)   irqmask <= writedata[WIDTH-1:0];
   end

   // read mux samples pre-write state every cycle, chipselect is not consulted
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         case (address)
            2'd0:    readdata <= 32'(deb);
            2'd1:    readdata <= 32'(irqmask);
            2'd2:    readdata <= 32'(ec);
            default: readdata <= '0;
         endcase
      end
   end

   assign irq = |(ec & irqmask);
endmodule

// File: tb/tb_nios_pio_in_irq.sv
// Bench for nios_pio_in_irq: three configurations share one bus; read expectations go through a queue.
module tb_nios_pio_in_irq;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0, write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [9:0]  pa = '0, pb = '0, pc = '0;
   logic [31:0] rda, rdb, rdc;
   logic        irqa, irqb, irqc;
   int          errors = 0, checks = 0, cyc = 0;

   typedef struct {int dut; logic [31:0] exp; string name;} exp_t;
   exp_t sb[$];
   exp_t x;

   // a: rising, debounce 4; b: any edge, no debounce; c: falling, debounce 4
   nios_pio_in_irq dut_a (.clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(pa), .readdata(rda), .irq(irqa));
   nios_pio_in_irq #(.DEBOUNCE_CYC(0), .EDGE_TYPE(2)) dut_b (.clk(clk), .reset_n(reset_n),
      .address(address), .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .in_port(pb), .readdata(rdb), .irq(irqb));
   nios_pio_in_irq #(.EDGE_TYPE(1)) dut_c (.clk(clk), .reset_n(reset_n), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata), .in_port(pc),
      .readdata(rdc), .irq(irqc));

   always #5 clk = ~clk;
   // edges seen since reset release; prescaler ticks on edges where this becomes a multiple of 4
   always @(posedge clk) if (!reset_n) cyc <= 0; else cyc <= cyc + 1;

   function automatic logic [31:0] got(input int d);
      return (d == 0) ? rda : (d == 1) ? rdb : rdc;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic rd(input int d, input logic [1:0] a, input logic [31:0] e, input string n);
      exp_t t;
      address = a; t.dut = d; t.exp = e; t.name = n;
      sb.push_back(t);
      @(negedge clk);
   endtask

   task automatic pop_cmp();
      x = sb.pop_front();
      checks++;
      if (got(x.dut) !== x.exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", x.name, got(x.dut), x.exp);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; pa = '1; pb = '1; pc = '1;
      repeat (3) begin
         chipselect = 1'b1; write_n = 1'b0;
         address = 2'($urandom_range(0, 3)); writedata = $urandom;
         @(negedge clk);
         checks++;
         if ({rda, rdb, rdc, irqa, irqb, irqc} !== '0) begin
            errors++;
            $display("FAIL rst_hold: got a=%h b=%h c=%h irq=%b%b%b expected all 0", rda, rdb, rdc, irqa, irqb, irqc);
         end
      end
      chipselect = 1'b0; write_n = 1'b1; writedata = '0; reset_n = 1'b1;
      rd(0, 2'd0, 32'h0, "rst_data");  pop_cmp();
      rd(0, 2'd1, 32'h0, "rst_mask");  pop_cmp();
      rd(0, 2'd2, 32'h0, "rst_ec");    pop_cmp();
      rd(0, 2'd3, 32'h0, "rst_rsvd");  pop_cmp();
      idle(10);
      // pins held high through reset rise once debounced
      rd(0, 2'd2, 32'h3FF, "rst_pin_rise_a"); pop_cmp();
      rd(1, 2'd2, 32'h3FF, "rst_pin_rise_b"); pop_cmp();
      rd(2, 2'd2, 32'h000, "rst_pin_rise_c"); pop_cmp();
      pa = '0; pb = '0; pc = '0;
      idle(20);
      wr(2'd2, '1);
      rd(0, 2'd2, 32'h0, "rst_cleanup_ec"); pop_cmp();
   endtask

   task automatic test_debounce();
      pa[0] = 1'b1; idle(3); pa[0] = 1'b0;
      idle(12);
      rd(0, 2'd0, 32'h000, "bounce_3clk"); pop_cmp();
      pa[0] = 1'b1;
      idle(10);
      rd(0, 2'd0, 32'h001, "step_within_10"); pop_cmp();
      wr(2'd2, 32'h1);
   endtask

   task automatic test_rise_irq();
      wr(2'd1, 32'h004);
      pa[2] = 1'b1;
      idle(12);
      rd(0, 2'd2, 32'h004, "rise_ec"); pop_cmp();
      checks++;
      if (irqa !== 1'b1) begin errors++; $display("FAIL rise_irq: got %b expected 1", irqa); end
      wr(2'd2, 32'h004);
      checks++;
      if (irqa !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b expected 0", irqa); end
      rd(0, 2'd2, 32'h000, "w1c_ec"); pop_cmp();
   endtask

   task automatic test_collision();
      int n0, t, target;
      pa[5] = 1'b1;
      n0 = cyc + 1;
      t = ((n0 + 5) / 4) * 4;   // first tick that sees the synchronised level
      target = t + 5;           // deb rises at t+4, event lands on edge t+5
      while (cyc + 1 < target) @(negedge clk);
      wr(2'd2, 32'h020);
      rd(0, 2'd2, 32'h020, "collision_set_wins"); pop_cmp();
      wr(2'd2, 32'h020);
      rd(0, 2'd2, 32'h000, "collision_then_clear"); pop_cmp();
   endtask

   task automatic test_mask();
      wr(2'd1, 32'h0);
      pa[1] = 1'b1;
      idle(12);
      rd(0, 2'd2, 32'h002, "masked_ec"); pop_cmp();
      checks++;
      if (irqa !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b expected 0", irqa); end
      wr(2'd1, 32'hFFFF_FFFF);
      checks++;
      if (rda !== 32'h0) begin errors++; $display("FAIL read_before_write: got %h expected 0", rda); end
      checks++;
      if (irqa !== 1'b1) begin errors++; $display("FAIL unmask_irq: got %b expected 1", irqa); end
      rd(0, 2'd1, 32'h3FF, "mask_width"); pop_cmp();
      wr(2'd3, '1);
      rd(0, 2'd3, 32'h0, "rsvd_write_ignored"); pop_cmp();
      wr(2'd0, 32'h0);
      rd(0, 2'd0, 32'h027, "data_write_ignored"); pop_cmp();
      wr(2'd1, 32'h0);
      wr(2'd2, '1);
   endtask

   task automatic test_modes();
      address = 2'd0; idle(1);
      pb[3] = 1'b1;
      // deb follows after 3 edges; readdata shows it on the next one
      idle(3);
      checks++;
      if (rdb !== 32'h0) begin errors++; $display("FAIL bypass_early: got %h expected 0", rdb); end
      idle(1);
      checks++;
      if (rdb !== 32'h008) begin errors++; $display("FAIL bypass_latency: got %h expected 008", rdb); end
      rd(1, 2'd2, 32'h008, "any_rise"); pop_cmp();
      wr(2'd2, 32'h008);
      pb[3] = 1'b0;
      idle(5);
      rd(1, 2'd2, 32'h008, "any_fall"); pop_cmp();
      pc[4] = 1'b1;
      idle(12);
      rd(2, 2'd0, 32'h010, "fall_mode_data"); pop_cmp();
      rd(2, 2'd2, 32'h000, "fall_mode_no_rise"); pop_cmp();
      pc[4] = 1'b0;
      idle(12);
      rd(2, 2'd2, 32'h010, "fall_mode_fall"); pop_cmp();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_debounce();
      test_rise_irq();
      test_collision();
      test_mask();
      test_modes();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
